// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245 transmit path.
package ft245_pkg;

    // Width of the per-state phase counter (parameters are limited to 1..15).
    localparam int CNT_W = 4;

    // Width of the running byte counter.
    localparam int BYTE_CNT_W = 32;

    // Transmit FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_TXE = 3'd1,
        SETUP    = 3'd2,
        STROBE   = 3'd3,
        HOLD     = 3'd4
    } state_t;

    // Selects which half of a pixel goes out next. byte_sel=0 is the first
    // byte on the wire; msb_first decides whether that is the high or low half.
    function automatic logic [7:0] pick_byte(input logic [15:0] word,
                                             input logic        sel,
                                             input logic        msb_first);
        return (sel ^ msb_first) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, with a
// parameterised reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= {2{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/fifo_ft245_tx.sv
// Pops 16-bit pixels from a first-word-fall-through FIFO and writes them as
// two bytes each to an FT245-style parallel interface. A pixel, once popped,
// is always sent in full; enable is only looked at between pixels.
//
// All pad-facing outputs are registered from the current state, so they
// trail the state register by one cycle. rinc and busy are registered from
// the next state so they line up with the state itself.
module fifo_ft245_tx
    import ft245_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int WR_CYCLES    = 3,
    parameter int HOLD_CYCLES  = 2,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  en,
    input  logic [15:0]           rdata,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic                  ft_txe_n,
    output logic [7:0]            ft_data,
    output logic                  ft_oe,
    output logic                  ft_wr,
    output logic                  busy,
    output logic [BYTE_CNT_W-1:0] byte_cnt
);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        phase_reg, phase_next;
    logic [15:0]             word_reg, word_next;
    logic                    byte_sel_reg, byte_sel_next;
    logic                    rinc_reg, rinc_next;
    logic                    busy_reg;
    logic                    ft_oe_reg;
    logic                    ft_wr_reg;
    logic [7:0]              ft_data_reg;
    logic [BYTE_CNT_W-1:0]   byte_cnt_reg;
    logic                    txe_s;

    // TXE# is asynchronous to rclk; the reset value reads as "not ready".
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_txe_sync (
        .clk  (rclk),
        .srst (rrst),
        .d    (ft_txe_n),
        .q    (txe_s)
    );

    // Next-state logic: phase counter reloads on every timed-state entry and
    // counts down to zero before leaving.
    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        word_next     = word_reg;
        byte_sel_next = byte_sel_reg;
        rinc_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (en && !rempty) begin
                    word_next     = rdata;
                    rinc_next     = 1'b1;
                    byte_sel_next = 1'b0;
                    state_next    = WAIT_TXE;
                end
            end
            WAIT_TXE: begin
                if (!txe_s) begin
                    state_next = SETUP;
                    phase_next = CNT_W'(SETUP_CYCLES - 1);
                end
            end
            SETUP: begin
                if (phase_reg == '0) begin
                    state_next = STROBE;
                    phase_next = CNT_W'(WR_CYCLES - 1);
                end else begin
                    phase_next = phase_reg - CNT_W'(1);
                end
            end
            STROBE: begin
                if (phase_reg == '0) begin
                    state_next = HOLD;
                    phase_next = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    phase_next = phase_reg - CNT_W'(1);
                end
            end
            HOLD: begin
                if (phase_reg == '0) begin
                    if (!byte_sel_reg) begin
                        byte_sel_next = 1'b1;
                        state_next    = WAIT_TXE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    phase_next = phase_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, captured word and phase counter.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            word_reg     <= '0;
            byte_sel_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            word_reg     <= word_next;
            byte_sel_reg <= byte_sel_next;
        end
    end

    // Registered outputs. ft_data only reloads in WAIT_TXE, so it cannot move
    // while the strobe is high or during the hold window. The byte counter
    // steps on the same edge that drops the strobe.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rinc_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            ft_oe_reg    <= 1'b0;
            ft_wr_reg    <= 1'b0;
            ft_data_reg  <= '0;
            byte_cnt_reg <= '0;
        end else begin
            rinc_reg  <= rinc_next;
            busy_reg  <= (state_next != IDLE);
            ft_oe_reg <= (state_reg != IDLE);
            ft_wr_reg <= (state_reg == STROBE);
            if (state_reg == WAIT_TXE) begin
                ft_data_reg <= pick_byte(word_reg, byte_sel_reg, MSB_FIRST);
            end
            if (ft_wr_reg && (state_reg != STROBE)) begin
                byte_cnt_reg <= byte_cnt_reg + BYTE_CNT_W'(1);
            end
        end
    end

    assign rinc     = rinc_reg;
    assign busy     = busy_reg;
    assign ft_oe    = ft_oe_reg;
    assign ft_wr    = ft_wr_reg;
    assign ft_data  = ft_data_reg;
    assign byte_cnt = byte_cnt_reg;

endmodule

// File: tb/tb_fifo_ft245_tx.sv
// Self-checking bench for fifo_ft245_tx: a queue-based FIFO, a byte-stream
// scoreboard with interface timing rules, and directed plus random traffic.
module tb_fifo_ft245_tx;

    localparam int S   = 2;
    localparam int W   = 3;
    localparam int H   = 2;
    localparam bit MSB = 1'b0;

    logic        rclk = 1'b0;
    logic        rrst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] rdata;
    logic        rempty;
    logic        rinc;
    logic        ft_txe_n = 1'b1;
    logic [7:0]  ft_data;
    logic        ft_oe;
    logic        ft_wr;
    logic        busy;
    logic [31:0] byte_cnt;

    fifo_ft245_tx #(
        .SETUP_CYCLES (S),
        .WR_CYCLES    (W),
        .HOLD_CYCLES  (H),
        .MSB_FIRST    (MSB)
    ) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .en       (en),
        .rdata    (rdata),
        .rempty   (rempty),
        .rinc     (rinc),
        .ft_txe_n (ft_txe_n),
        .ft_data  (ft_data),
        .ft_oe    (ft_oe),
        .ft_wr    (ft_wr),
        .busy     (busy),
        .byte_cnt (byte_cnt)
    );

    always #5 rclk = ~rclk;

    // FIFO model: first-word fall-through view of a queue.
    logic [15:0] fifo_q[$];
    assign rempty = (fifo_q.size() == 0);
    assign rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic rst_edge = 1'b0;

    always @(posedge rclk) begin
        cyc      <= cyc + 1;
        rst_edge <= rrst;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    int   completed = 0;
    int   n_rinc = 0;
    int   n_rise = 0;
    int   last_rinc_cyc = 0;
    int   last_rise_cyc = 0;
    logic started = 1'b0;
    logic wr_prev = 1'b0, rinc_prev = 1'b0, en_prev = 1'b0, empty_prev = 1'b1;
    int   wr_len = 0;
    int   since_fall = H;
    logic [7:0] wr_data = '0;
    logic [7:0] data_prev = '0;
    int   data_age = 0;
    logic txe_log [0:15];

    initial begin
        for (int i = 0; i < 16; i++) txe_log[i] = 1'b1;
    end

    // One compare process, mid-cycle: interface rules and byte order.
    always @(negedge rclk) begin
        if (rst_edge) begin
            chk("rst_rinc", rinc, 0);
            chk("rst_ft_wr", ft_wr, 0);
            chk("rst_ft_oe", ft_oe, 0);
            chk("rst_busy", busy, 0);
            chk("rst_byte_cnt", byte_cnt, 0);
            chk("rst_ft_data", ft_data, 0);
            exp_q.delete();
            completed  = 0;
            wr_prev    = 1'b0;
            wr_len     = 0;
            since_fall = H;
            data_prev  = ft_data;
            data_age   = 0;
            rinc_prev  = 1'b0;
            started    = 1'b1;
        end else if (started) begin
            if (ft_data == data_prev) data_age++;
            else data_age = 0;
            data_prev = ft_data;

            if (rinc) begin
                chk("rinc_single_cycle", rinc_prev, 0);
                chk("rinc_needs_en", en_prev, 1);
                chk("rinc_needs_data", empty_prev, 0);
                n_rinc++;
                last_rinc_cyc = cyc;
                if (fifo_q.size() != 0) begin
                    logic [15:0] w;
                    w = fifo_q.pop_front();
                    if (MSB) begin
                        exp_q.push_back(w[15:8]);
                        exp_q.push_back(w[7:0]);
                    end else begin
                        exp_q.push_back(w[7:0]);
                        exp_q.push_back(w[15:8]);
                    end
                end
            end

            if (ft_wr && !wr_prev) begin
                chk("setup_time_ok", (data_age >= S), 1);
                chk("txe_low_before_wr", txe_log[(cyc - (S + 4) + 1600) % 16], 0);
                wr_data = ft_data;
                wr_len  = 1;
                n_rise++;
                last_rise_cyc = cyc;
            end else if (ft_wr) begin
                wr_len++;
                chk("data_stable_wr", ft_data, wr_data);
            end
            if (ft_wr) chk("oe_during_wr", ft_oe, 1);

            if (!ft_wr && wr_prev) begin
                chk("wr_width", wr_len, W);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL byte_order: got %0h expected none (cycle %0d)", wr_data, cyc);
                end else begin
                    chk("byte_order", wr_data, exp_q.pop_front());
                end
                completed++;
                log_q.push_back(wr_data);
                since_fall = 0;
            end
            if (since_fall < H) begin
                chk("data_hold", ft_data, wr_data);
                since_fall++;
            end

            chk("byte_cnt", byte_cnt, completed);
            if (!busy) begin
                chk("whole_pixel_idle", exp_q.size(), 0);
                chk("no_wr_idle", ft_wr, 0);
            end
            wr_prev   = ft_wr;
            rinc_prev = rinc;
        end
        en_prev    = en;
        empty_prev = rempty;
        txe_log[cyc % 16] = ft_txe_n;
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic wait_rinc(input int target, input string name);
        for (int i = 0; i < 400; i++) begin
            if (n_rinc >= target) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic wait_rise(input int target, input string name);
        for (int i = 0; i < 400; i++) begin
            if (n_rise >= target) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 400; i++) begin
            if (completed >= target) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            if (!busy) return;
            tick();
        end
        timeout(name);
    endtask

    initial begin
        int rel, n0, r0, c0, stall;
        logic [7:0] first_byte, second_byte;

        // Reset held 3 cycles with data available and enable high.
        rrst     = 1'b1;
        en       = 1'b1;
        ft_txe_n = 1'b0;
        fifo_q.push_back(16'hBEEF);
        repeat (3) tick();
        rrst = 1'b0;
        rel  = cyc;
        wait_rinc(1, "first_rinc");
        chk("rinc_after_release", last_rinc_cyc - rel, 1);
        wait_idle("reset_word_idle");

        // Single word, TXE already low.
        log_q.delete();
        n0 = n_rinc;
        r0 = n_rise;
        fifo_q.push_back(16'hA55A);
        wait_rinc(n0 + 1, "single_rinc");
        wait_rise(r0 + 1, "single_rise");
        chk("single_rise_latency", last_rise_cyc - last_rinc_cyc, 4);
        wait_idle("single_idle");
        chk("single_nbytes", log_q.size(), 2);
        first_byte  = (log_q.size() > 0) ? log_q[0] : 8'h00;
        second_byte = (log_q.size() > 1) ? log_q[1] : 8'h00;
        chk("single_byte0", first_byte, 8'h5A);
        chk("single_byte1", second_byte, 8'hA5);
        chk("single_nrinc", n_rinc - n0, 1);
        chk("single_byte_cnt", byte_cnt, 4);

        // Flow control: TXE# goes high during the first byte's strobe.
        log_q.delete();
        n0 = n_rinc;
        r0 = n_rise;
        c0 = completed;
        fifo_q.push_back(16'h1234);
        wait_rinc(n0 + 1, "flow_rinc");
        wait_rise(r0 + 1, "flow_rise0");
        ft_txe_n = 1'b1;
        wait_done(c0 + 1, "flow_byte0");
        repeat (3) tick();
        for (int i = 0; i < 44; i++) begin
            chk("flow_wr_low", ft_wr, 0);
            chk("flow_busy", busy, 1);
            chk("flow_data_held", ft_data, 8'h12);
            tick();
        end
        ft_txe_n = 1'b0;
        rel = cyc;
        wait_rise(r0 + 2, "flow_rise1");
        chk("flow_resume_latency", last_rise_cyc - rel, S + 4);
        wait_idle("flow_idle");
        first_byte  = (log_q.size() > 0) ? log_q[0] : 8'h00;
        second_byte = (log_q.size() > 1) ? log_q[1] : 8'h00;
        chk("flow_byte0", first_byte, 8'h34);
        chk("flow_byte1", second_byte, 8'h12);

        // Enable drop during the first byte of the second word.
        log_q.delete();
        n0 = n_rinc;
        r0 = n_rise;
        for (int i = 0; i < 4; i++) fifo_q.push_back(16'($urandom));
        wait_rinc(n0 + 2, "endrop_rinc2");
        wait_rise(r0 + 3, "endrop_rise");
        en = 1'b0;
        wait_idle("endrop_idle");
        repeat (30) tick();
        chk("endrop_nbytes", log_q.size(), 4);
        chk("endrop_nrinc", n_rinc - n0, 2);
        chk("endrop_left", fifo_q.size(), 2);
        chk("endrop_busy", busy, 0);
        fifo_q.delete();

        // Random stream of 256 words with TXE# stalls and enable blips.
        rrst = 1'b1;
        repeat (2) tick();
        rrst = 1'b0;
        log_q.delete();
        n0 = n_rinc;
        for (int i = 0; i < 256; i++) fifo_q.push_back(16'($urandom));
        stall = 0;
        begin
            int t;
            for (t = 0; t < 20000; t++) begin
                if (fifo_q.size() == 0 && !busy) break;
                if (stall > 0) stall--;
                else if ($urandom_range(0, 15) == 0) stall = $urandom_range(1, 12);
                ft_txe_n = (stall > 0);
                en = ($urandom_range(0, 19) != 0);
                tick();
            end
            if (t >= 20000) timeout("stream_drain");
        end
        en       = 1'b1;
        ft_txe_n = 1'b0;
        repeat (30) tick();
        chk("stream_byte_cnt", byte_cnt, 512);
        chk("stream_nbytes", log_q.size(), 512);
        chk("stream_nrinc", n_rinc - n0, 256);

        // Reset in the middle of a strobe.
        r0 = n_rise;
        n0 = n_rinc;
        fifo_q.push_back(16'h0FF0);
        wait_rinc(n0 + 1, "mid_rinc");
        wait_rise(r0 + 1, "mid_rise");
        chk("mid_wr_high", ft_wr, 1);
        rrst = 1'b1;
        tick();
        chk("mid_wr_dropped", ft_wr, 0);
        rrst = 1'b0;
        en   = 1'b0;
        fifo_q.delete();
        n0 = n_rinc;
        repeat (30) tick();
        chk("mid_byte_cnt", byte_cnt, 0);
        chk("mid_no_rinc", n_rinc - n0, 0);
        chk("mid_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
